// File: rtl/hilo_div_unit.sv
// hilo_div_unit: HI/LO register pair with NUM_WR priority-ordered write channels and an
// iterative restoring signed/unsigned divider (quotient -> LO, remainder -> HI).
// Optional build macro: HILO_BYPASS_EN forwards the next HI/LO values combinationally to rd_*.
module hilo_div_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned NUM_WR = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_WR-1:0]        wr_hi_en,
   input  logic [NUM_WR-1:0]        wr_lo_en,
   input  logic [NUM_WR*DATA_W-1:0] wr_hi_data,
   input  logic [NUM_WR*DATA_W-1:0] wr_lo_data,
   input  logic                     div_start,
   input  logic                     div_signed,
   input  logic [DATA_W-1:0]        div_a,
   input  logic [DATA_W-1:0]        div_b,
   input  logic                     div_abort,
   output logic                     busy,
   output logic                     div_done,
   output logic [DATA_W-1:0]        rd_hi,
   output logic [DATA_W-1:0]        rd_lo
);

   localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

   state_e              state_q;
   logic [CntW-1:0]     cnt_q;
   logic [DATA_W-1:0]   a_q, b_q;        // raw operands as sampled with div_start
   logic                sgn_q;
   logic [DATA_W-1:0]   quo_q;           // dividend shifts out as quotient shifts in
   logic [DATA_W-1:0]   dvs_q;
   logic [DATA_W-1:0]   rem_q;
   logic                neg_quo_q, neg_rem_q, zero_q;
   logic                busy_q, done_q;
   logic [DATA_W-1:0]   hi_q, lo_q, hi_d, lo_d;

   logic [DATA_W-1:0]   a_abs, b_abs;
   logic [DATA_W:0]     rem_sh;
   logic [DATA_W-1:0]   rem_sub;
   logic                take;
   logic [DATA_W-1:0]   div_hi, div_lo;
   logic                commit;

   // Operand magnitudes, one restoring step and the sign-corrected final result
   always_comb begin
      a_abs   = (sgn_q && a_q[DATA_W-1]) ? -a_q : a_q;
      b_abs   = (sgn_q && b_q[DATA_W-1]) ? -b_q : b_q;
      rem_sh  = {rem_q, quo_q[DATA_W-1]};
      take    = (rem_sh >= {1'b0, dvs_q});
      // When take is set the difference is below the divisor, so DATA_W bits suffice
      rem_sub = rem_sh[DATA_W-1:0] - dvs_q;
      if (zero_q) begin
         div_lo = '1;
         div_hi = a_q;
      end else begin
         div_lo = neg_quo_q ? -quo_q : quo_q;
         div_hi = neg_rem_q ? -rem_q : rem_q;
      end
   end

   // Divider FSM with registered busy/done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         sgn_q     <= 1'b0;
         quo_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (div_start && !div_abort) begin
                  a_q     <= div_a;
                  b_q     <= div_b;
                  sgn_q   <= div_signed;
                  busy_q  <= 1'b1;
                  state_q <= StPrep;
               end
            end
            StPrep: begin
               if (div_abort) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  quo_q     <= a_abs;
                  dvs_q     <= b_abs;
                  rem_q     <= '0;
                  cnt_q     <= CntW'(DATA_W - 1);
                  neg_quo_q <= sgn_q && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                  neg_rem_q <= sgn_q && a_q[DATA_W-1];
                  zero_q    <= (b_q == '0);
                  state_q   <= StIter;
               end
            end
            StIter: begin
               if (div_abort) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  quo_q <= {quo_q[DATA_W-2:0], take};
                  rem_q <= take ? rem_sub : rem_sh[DATA_W-1:0];
                  if (cnt_q == '0) state_q <= StFix;
                  else             cnt_q   <= cnt_q - 1'b1;
               end
            end
            StFix: begin
               busy_q  <= 1'b0;
               done_q  <= !div_abort;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign commit = (state_q == StFix) && !div_abort;

   // Next HI/LO: divider commit first, then channels in ascending (older to younger) order
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (commit) begin
         hi_d = div_hi;
         lo_d = div_lo;
      end
      for (int unsigned i = 0; i < NUM_WR; i++) begin
         if (wr_hi_en[i]) hi_d = wr_hi_data[i*DATA_W +: DATA_W];
         if (wr_lo_en[i]) lo_d = wr_lo_data[i*DATA_W +: DATA_W];
      end
   end

   // HI/LO storage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign busy     = busy_q;
   assign div_done = done_q;

`ifdef HILO_BYPASS_EN
   assign rd_hi = hi_d;
   assign rd_lo = lo_d;
`else
   assign rd_hi = hi_q;
   assign rd_lo = lo_q;
`endif

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit (DATA_W=32, NUM_WR=2, default build).
module tb_hilo_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  wr_hi_en, wr_lo_en;
   logic [63:0] wr_hi_data, wr_lo_data;
   logic        div_start, div_signed, div_abort;
   logic [31:0] div_a, div_b;
   logic        busy, div_done;
   logic [31:0] rd_hi, rd_lo;

   int n_checks = 0;
   int n_errors = 0;

   hilo_div_unit #(.DATA_W(32), .NUM_WR(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_hi_en   (wr_hi_en),
      .wr_lo_en   (wr_lo_en),
      .wr_hi_data (wr_hi_data),
      .wr_lo_data (wr_lo_data),
      .div_start  (div_start),
      .div_signed (div_signed),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_abort  (div_abort),
      .busy       (busy),
      .div_done   (div_done),
      .rd_hi      (rd_hi),
      .rd_lo      (rd_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Launch one division and check latency, done pulse and results
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
      int cycles;
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = sgn;
      div_a      = a;
      div_b      = b;
      @(posedge clk);
      #1 div_start = 1'b0;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         @(posedge clk);
         #1;
      end
      check({tag, " busy_cycles"}, cycles, 32'd34);
      check({tag, " done"}, {31'd0, div_done}, 32'd1);
      check({tag, " lo"}, rd_lo, exp_lo);
      check({tag, " hi"}, rd_hi, exp_hi);
      @(posedge clk);
      #1 check({tag, " done_clear"}, {31'd0, div_done}, 32'd0);
   endtask

   // Wait n cycles and report whether div_done ever rose
   task automatic watch_no_done(input string tag, input int n);
      logic seen;
      seen = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1 if (div_done) seen = 1'b1;
      end
      check({tag, " no_done"}, {31'd0, seen}, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      wr_hi_en   = '0;
      wr_lo_en   = '0;
      wr_hi_data = '0;
      wr_lo_data = '0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      div_abort  = 1'b0;
      div_a      = '0;
      div_b      = '0;
      #12;
      check("rst hi", rd_hi, 32'h0);
      check("rst lo", rd_lo, 32'h0);
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, div_done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Preload LO from channel 0, then both channels write HI on one edge
      @(negedge clk);
      wr_lo_en   = 2'b01;
      wr_lo_data = {32'h0, 32'h5555_5555};
      @(negedge clk);
      wr_lo_en   = 2'b00;
      wr_hi_en   = 2'b11;
      wr_hi_data = {32'h2222_2222, 32'h1111_1111};
      @(posedge clk);
      #1 wr_hi_en = 2'b00;
      check("prio hi", rd_hi, 32'h2222_2222);
      check("prio lo kept", rd_lo, 32'h5555_5555);

      run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
      run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
      run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
      run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
      run_div("div -9/0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF7);
      run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);

      // Abort around cycle 10 leaves HI/LO alone and never pulses done
      @(negedge clk);
      wr_hi_en   = 2'b01;
      wr_lo_en   = 2'b01;
      wr_hi_data = {32'h0, 32'hAAAA_0000};
      wr_lo_data = {32'h0, 32'h0000_BBBB};
      @(negedge clk);
      wr_hi_en   = 2'b00;
      wr_lo_en   = 2'b00;
      div_start  = 1'b1;
      div_signed = 1'b0;
      div_a      = 32'd100;
      div_b      = 32'd3;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      div_abort = 1'b1;
      @(posedge clk);
      #1 div_abort = 1'b0;
      check("abort busy", {31'd0, busy}, 32'd0);
      watch_no_done("abort", 40);
      check("abort hi", rd_hi, 32'hAAAA_0000);
      check("abort lo", rd_lo, 32'h0000_BBBB);

      // Abort together with start in IDLE drops the start
      @(negedge clk);
      div_start = 1'b1;
      div_abort = 1'b1;
      @(posedge clk);
      #1;
      div_start = 1'b0;
      div_abort = 1'b0;
      check("abort+start busy", {31'd0, busy}, 32'd0);
      watch_no_done("abort+start", 40);
      check("abort+start lo", rd_lo, 32'h0000_BBBB);

      // DIVU 9/4 with an ignored restart mid-flight and a ch1 LO write on the FIX edge
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b0;
      div_a      = 32'd9;
      div_b      = 32'd4;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b1;
      div_a      = 32'd1000;
      div_b      = 32'd1;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (28) @(posedge clk);
      #1 check("collide busy before fix", {31'd0, busy}, 32'd1);
      @(negedge clk);
      wr_lo_en   = 2'b10;
      wr_lo_data = {32'h0000_ABCD, 32'h1234_5678};
      @(posedge clk);
      #1 wr_lo_en = 2'b00;
      check("collide done", {31'd0, div_done}, 32'd1);
      check("collide lo", rd_lo, 32'h0000_ABCD);
      check("collide hi", rd_hi, 32'd1);
      check("collide busy after", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of a division
      @(negedge clk);
      div_start = 1'b1;
      div_a     = 32'd100;
      div_b     = 32'd7;
      @(posedge clk);
      #1 div_start = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async rst hi", rd_hi, 32'h0);
      check("async rst lo", rd_lo, 32'h0);
      check("async rst busy", {31'd0, busy}, 32'd0);
      check("async rst done", {31'd0, div_done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      watch_no_done("after rst", 40);
      check("after rst lo", rd_lo, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
